// File: rtl/alu_seq_param_if.sv
// Handshake bundle for alu_seq_param: operand channel (in_*) and result channel (out_*).
interface alu_seq_param_if #(
    parameter int unsigned WIDTH = 8
);
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic [2:0]           opcode;
    logic                 out_valid;
    logic                 out_ready;
    logic [2*WIDTH-1:0]   result;
    logic                 cout;
    logic                 zero;
    logic                 busy;

    modport master (
        output in_valid, a, b, opcode, out_ready,
        input  in_ready, out_valid, result, cout, zero, busy
    );

    modport slave (
        input  in_valid, a, b, opcode, out_ready,
        output in_ready, out_valid, result, cout, zero, busy
    );
endinterface

// File: rtl/alu_seq_param.sv
// Registered WIDTH-bit ALU with single-slot valid/ready handshake and an iterative
// shift-add multiplier; result is 2*WIDTH bits with carry/borrow and zero flags.
module alu_seq_param #(
    parameter int unsigned WIDTH = 8
) (
    input logic            clk,
    input logic            rst_n,
    alu_seq_param_if.slave bus
);
    localparam int unsigned CntW = $clog2(WIDTH + 1);

    localparam logic [2:0] OpAdd = 3'b000;
    localparam logic [2:0] OpSub = 3'b001;
    localparam logic [2:0] OpMul = 3'b010;
    localparam logic [2:0] OpShl = 3'b011;
    localparam logic [2:0] OpShr = 3'b100;
    localparam logic [2:0] OpAnd = 3'b101;
    localparam logic [2:0] OpOr  = 3'b110;
    localparam logic [2:0] OpXor = 3'b111;

    typedef enum logic [1:0] {StIdle, StMul, StDone} state_e;

    state_e               state_q;
    logic [2*WIDTH-1:0]   acc_q;
    logic [2*WIDTH-1:0]   mcand_q;
    logic [WIDTH-1:0]     mplr_q;
    logic [CntW-1:0]      cnt_q;
    logic [2*WIDTH-1:0]   result_q;
    logic                 cout_q;
    logic                 zero_q;
    logic                 out_valid_q;
    logic                 busy_q;

    logic                 accept;
    logic [WIDTH:0]       sum;
    logic [WIDTH:0]       diff;
    logic [2*WIDTH-1:0]   alu_res;
    logic                 alu_cout;
    logic [2*WIDTH-1:0]   acc_step;

    assign bus.in_ready  = (state_q == StIdle) && rst_n;
    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.cout      = cout_q;
    assign bus.zero      = zero_q;
    assign bus.busy      = busy_q;

    assign accept   = bus.in_valid && bus.in_ready;
    assign acc_step = mplr_q[0] ? (acc_q + mcand_q) : acc_q;

    // Single-cycle ops are evaluated straight from the inputs at the accept edge.
    always_comb begin
        sum      = {1'b0, bus.a} + {1'b0, bus.b};
        diff     = {1'b0, bus.a} - {1'b0, bus.b};
        alu_res  = '0;
        alu_cout = 1'b0;
        unique case (bus.opcode)
            OpAdd: begin
                alu_res[WIDTH:0] = sum;
                alu_cout         = sum[WIDTH];
            end
            OpSub: begin
                alu_res[WIDTH-1:0] = diff[WIDTH-1:0];
                alu_cout           = diff[WIDTH];
            end
            OpMul: alu_res = '0;
            OpShl: begin
                alu_res[WIDTH:0] = {bus.a, 1'b0};
                alu_cout         = bus.a[WIDTH-1];
            end
            OpShr: begin
                alu_res[WIDTH-1:0] = {1'b0, bus.a[WIDTH-1:1]};
                alu_cout           = bus.a[0];
            end
            OpAnd: alu_res[WIDTH-1:0] = bus.a & bus.b;
            OpOr:  alu_res[WIDTH-1:0] = bus.a | bus.b;
            OpXor: alu_res[WIDTH-1:0] = bus.a ^ bus.b;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            acc_q       <= '0;
            mcand_q     <= '0;
            mplr_q      <= '0;
            cnt_q       <= '0;
            result_q    <= '0;
            cout_q      <= 1'b0;
            zero_q      <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (accept) begin
                        busy_q <= 1'b1;
                        if (bus.opcode == OpMul) begin
                            acc_q   <= '0;
                            mcand_q <= {{WIDTH{1'b0}}, bus.a};
                            mplr_q  <= bus.b;
                            cnt_q   <= CntW'(WIDTH);
                            state_q <= StMul;
                        end else begin
                            result_q    <= alu_res;
                            cout_q      <= alu_cout;
                            zero_q      <= (alu_res == '0);
                            out_valid_q <= 1'b1;
                            state_q     <= StDone;
                        end
                    end
                end
                StMul: begin
                    acc_q   <= acc_step;
                    mcand_q <= mcand_q << 1;
                    mplr_q  <= mplr_q >> 1;
                    cnt_q   <= cnt_q - 1'b1;
                    // Last step: publish the product including this step's partial add.
                    if (cnt_q == CntW'(1)) begin
                        result_q    <= acc_step;
                        cout_q      <= 1'b0;
                        zero_q      <= (acc_step == '0);
                        out_valid_q <= 1'b1;
                        state_q     <= StDone;
                    end
                end
                StDone: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        state_q     <= StIdle;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                    state_q     <= StIdle;
                end
            endcase
        end
    end
endmodule
